// File: rtl/nonce_pkg.sv
// rtl/nonce_pkg.sv - shared state encoding and default parameters for the nonce dispatcher
// Contents:
//   DEF_PIPE_LATENCY : default issue-to-hit latency of the hash pipeline
//   DEF_FIFO_DEPTH   : default golden-nonce buffer depth
//   DEF_GAP_CYCLES   : default minimum spacing of new_golden_nonce pulses
//   state_t          : dispatcher FSM states
package nonce_pkg;

    localparam int DEF_PIPE_LATENCY = 64;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_GAP_CYCLES   = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nonce_hit_fifo.sv
// rtl/nonce_hit_fifo.sv - synchronous hit buffer with push/pop/flush
// Ports:
//   hash_clk, reset_n : clock, asynchronous active-low reset
//   flush             : empty the buffer (overrides push/pop)
//   push, push_data   : write an entry; caller guarantees room (or a same-cycle pop)
//   pop               : drop the head entry; caller guarantees non-empty
//   head              : oldest entry
//   full, empty       : occupancy flags
module nonce_hit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             hash_clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
    // out this cycle before the slot is overwritten at the edge.
    always_ff @(posedge hash_clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// rtl/nonce_dispatcher.sv - issues a nonce range to a hash pipeline and paces golden-nonce reports
// Optional feature: define NONCE_DISPATCHER_STATS_EN to build the per-job hit counter.
// Ports:
//   hash_clk, reset_n        : clock, asynchronous active-low reset
//   new_work, nonce_min/max  : start (or restart) a job over [nonce_min, nonce_max]
//   core_valid, core_nonce   : nonce issued to the pipeline
//   hit_valid, hit_nonce     : hit reported by the pipeline
//   golden_nonce             : last forwarded hit, held
//   new_golden_nonce         : one-cycle pulse on golden_nonce update
//   busy, exhausted          : RUN/DRAIN, DONE
//   hit_overflow, hit_count  : sticky drop flag, accepted hits this job
module nonce_dispatcher
    import nonce_pkg::*;
#(
    parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic        hash_clk,
    input  logic        reset_n,
    input  logic        new_work,
    input  logic [31:0] nonce_min,
    input  logic [31:0] nonce_max,
    output logic        core_valid,
    output logic [31:0] core_nonce,
    input  logic        hit_valid,
    input  logic [31:0] hit_nonce,
    output logic [31:0] golden_nonce,
    output logic        new_golden_nonce,
    output logic        busy,
    output logic        exhausted,
    output logic        hit_overflow,
    output logic [15:0] hit_count
);

    localparam int LW = (PIPE_LATENCY < 1) ? 1 : $clog2(PIPE_LATENCY + 1);
    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    state_t        state;
    logic [31:0]   nonce;
    logic [31:0]   nonce_last;
    logic [LW-1:0] drain_cnt;
    logic [LW-1:0] discard_cnt;
    logic [GW-1:0] gap_cnt;

    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_head;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign core_valid = (state == ST_RUN);
    assign core_nonce = nonce;
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign exhausted  = (state == ST_DONE);

    // new_work flushes the buffer, so nothing is pushed or popped that cycle.
    assign push_req = hit_valid && (discard_cnt == '0) && !new_work;
    assign pop      = !fifo_empty && (gap_cnt == '0) && !new_work;
    assign push_ok  = push_req && (!fifo_full || pop);

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            nonce      <= '0;
            nonce_last <= '0;
            drain_cnt  <= '0;
        end else if (new_work) begin
            // Same handling in every state: a job in flight is simply abandoned.
            nonce_last <= nonce_max;
            drain_cnt  <= '0;
            if (nonce_min <= nonce_max) begin
                state <= ST_RUN;
                nonce <= nonce_min;
            end else begin
                state <= ST_DONE;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    // Compare before incrementing so nonce_max = FFFFFFFF never wraps.
                    if (nonce == nonce_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= LW'(PIPE_LATENCY);
                    end else begin
                        nonce <= nonce + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= LW'(1)) state <= ST_DONE;
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Hits still in the pipeline from an abandoned job are ignored for one pipeline latency.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n)               discard_cnt <= '0;
        else if (new_work)          discard_cnt <= LW'(PIPE_LATENCY);
        else if (discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            golden_nonce     <= '0;
            new_golden_nonce <= 1'b0;
            gap_cnt          <= '0;
        end else begin
            new_golden_nonce <= pop;
            if (pop) begin
                golden_nonce <= fifo_head;
                gap_cnt      <= GW'(GAP_CYCLES - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n)                 hit_overflow <= 1'b0;
        else if (new_work)            hit_overflow <= 1'b0;
        else if (push_req && !push_ok) hit_overflow <= 1'b1;
    end

`ifdef NONCE_DISPATCHER_STATS_EN
    logic [15:0] hit_cnt_q;

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n)                            hit_cnt_q <= '0;
        else if (new_work)                       hit_cnt_q <= '0;
        else if (push_ok && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
    end

    assign hit_count = hit_cnt_q;
`else
    assign hit_count = '0;
`endif

    nonce_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .hash_clk  (hash_clk),
        .reset_n   (reset_n),
        .flush     (new_work),
        .push      (push_ok),
        .push_data (hit_nonce),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb/tb_nonce_dispatcher.sv - directed self-checking bench for nonce_dispatcher
module tb_nonce_dispatcher;

    logic        hash_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_work = 1'b0;
    logic [31:0] nonce_min = '0;
    logic [31:0] nonce_max = '0;
    logic        hit_valid = 1'b0;
    logic [31:0] hit_nonce = '0;
    logic        core_valid;
    logic [31:0] core_nonce;
    logic [31:0] golden_nonce;
    logic        new_golden_nonce;
    logic        busy;
    logic        exhausted;
    logic        hit_overflow;
    logic [15:0] hit_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] pq[$];
    int          pt[$];

`ifdef NONCE_DISPATCHER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    nonce_dispatcher dut (
        .hash_clk         (hash_clk),
        .reset_n          (reset_n),
        .new_work         (new_work),
        .nonce_min        (nonce_min),
        .nonce_max        (nonce_max),
        .core_valid       (core_valid),
        .core_nonce       (core_nonce),
        .hit_valid        (hit_valid),
        .hit_nonce        (hit_nonce),
        .golden_nonce     (golden_nonce),
        .new_golden_nonce (new_golden_nonce),
        .busy             (busy),
        .exhausted        (exhausted),
        .hit_overflow     (hit_overflow),
        .hit_count        (hit_count)
    );

    always #5 hash_clk = ~hash_clk;

    always @(posedge hash_clk) cyc <= cyc + 1;

    always @(negedge hash_clk) begin
        if (new_golden_nonce === 1'b1) begin
            pq.push_back(golden_nonce);
            pt.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge hash_clk);
    endtask

    task automatic pulse_work(input logic [31:0] lo, input logic [31:0] hi);
        @(negedge hash_clk);
        nonce_min = lo;
        nonce_max = hi;
        new_work  = 1'b1;
        @(negedge hash_clk);
        new_work  = 1'b0;
    endtask

    task automatic test_reset;
        idle(2);
        checks++;
        if ({core_valid, busy, exhausted, new_golden_nonce, hit_overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {core_valid, busy, exhausted, new_golden_nonce, hit_overflow});
        end
        checks++;
        if (core_nonce !== 32'd0) begin errors++; $display("FAIL reset_core_nonce: got %h expected 0", core_nonce); end
        checks++;
        if (golden_nonce !== 32'd0) begin errors++; $display("FAIL reset_golden: got %h expected 0", golden_nonce); end
        checks++;
        if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_hit_count: got %h expected 0", hit_count); end
        @(negedge hash_clk);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_range;
        int n;
        pulse_work(32'd10, 32'd13);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (core_valid !== 1'b1 || core_nonce !== 32'(10 + i)) begin
                errors++;
                $display("FAIL range_issue%0d: got valid=%b nonce=%h expected valid=1 nonce=%h", i, core_valid, core_nonce, 32'(10 + i));
            end
            @(negedge hash_clk);
        end
        checks++;
        if (core_valid !== 1'b0 || busy !== 1'b1 || exhausted !== 1'b0) begin
            errors++;
            $display("FAIL range_drain_entry: got valid=%b busy=%b exh=%b expected 0 1 0", core_valid, busy, exhausted);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge hash_clk);
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL range_drain_len: got %0d expected 64", n); end
        checks++;
        if (exhausted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL range_done: got exh=%b busy=%b expected 1 0", exhausted, busy);
        end
    endtask

    task automatic test_wrap;
        int seen;
        pulse_work(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        checks++;
        if (core_valid !== 1'b1 || core_nonce !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_first: got valid=%b nonce=%h expected 1 fffffffe", core_valid, core_nonce);
        end
        @(negedge hash_clk);
        checks++;
        if (core_valid !== 1'b1 || core_nonce !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_second: got valid=%b nonce=%h expected 1 ffffffff", core_valid, core_nonce);
        end
        @(negedge hash_clk);
        checks++;
        if (core_valid !== 1'b0 || core_nonce !== 32'hFFFF_FFFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_nowrap: got valid=%b nonce=%h busy=%b expected 0 ffffffff 1", core_valid, core_nonce, busy);
        end
        // Inverted range, issued as an abort in DRAIN.
        pulse_work(32'd5, 32'd4);
        checks++;
        if (exhausted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_range_done: got exh=%b busy=%b expected 1 0", exhausted, busy);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_valid !== 1'b0) seen++;
            @(negedge hash_clk);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL empty_range_issue: got %0d valid cycles expected 0", seen); end
        idle(70);
    endtask

    task automatic test_gap;
        int x;
        pq.delete();
        pt.delete();
        @(negedge hash_clk);
        x = cyc;
        hit_valid = 1'b1; hit_nonce = 32'hA1;
        @(negedge hash_clk); hit_nonce = 32'hA2;
        @(negedge hash_clk); hit_nonce = 32'hA3;
        @(negedge hash_clk); hit_valid = 1'b0;
        idle(800);
        checks++;
        if (pq.size() != 3) begin
            errors++;
            $display("FAIL gap_count: got %0d pulses expected 3", pq.size());
        end else begin
            checks++;
            if (pq[0] !== 32'hA1 || pq[1] !== 32'hA2 || pq[2] !== 32'hA3) begin
                errors++;
                $display("FAIL gap_values: got %h %h %h expected a1 a2 a3", pq[0], pq[1], pq[2]);
            end
            checks++;
            if (pt[0] != x + 2) begin errors++; $display("FAIL gap_latency: got cycle %0d expected %0d", pt[0], x + 2); end
            checks++;
            if (pt[1] - pt[0] != 256 || pt[2] - pt[1] != 256) begin
                errors++;
                $display("FAIL gap_spacing: got %0d %0d expected 256 256", pt[1] - pt[0], pt[2] - pt[1]);
            end
        end
        checks++;
        if (hit_count !== (STATS ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL gap_hit_count: got %0d expected %0d", hit_count, STATS ? 3 : 0);
        end
    endtask

    task automatic test_overflow;
        pq.delete();
        pt.delete();
        checks++;
        if (hit_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b expected 0", hit_overflow); end
        for (int i = 0; i < 6; i++) begin
            @(negedge hash_clk);
            hit_valid = 1'b1;
            hit_nonce = 32'(100 + i);
        end
        @(negedge hash_clk);
        hit_valid = 1'b0;
        checks++;
        if (hit_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", hit_overflow); end
        idle(1300);
        checks++;
        if (pq.size() != 5) begin
            errors++;
            $display("FAIL ovf_pulses: got %0d expected 5", pq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pq[i] !== 32'(100 + i)) begin
                    errors++;
                    $display("FAIL ovf_value%0d: got %h expected %h", i, pq[i], 32'(100 + i));
                end
            end
        end
        checks++;
        if (hit_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", hit_overflow); end
        checks++;
        if (hit_count !== (STATS ? 16'd8 : 16'd0)) begin
            errors++;
            $display("FAIL ovf_hit_count: got %0d expected %0d", hit_count, STATS ? 8 : 0);
        end
    endtask

    task automatic test_abort;
        pulse_work(32'd1000, 32'd5000);
        checks++;
        if (hit_overflow !== 1'b0 || hit_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_clear: got ovf=%b count=%0d expected 0 0", hit_overflow, hit_count);
        end
        idle(70);
        pq.delete();
        pt.delete();
        @(negedge hash_clk); hit_valid = 1'b1; hit_nonce = 32'd7;
        @(negedge hash_clk); hit_nonce = 32'd8;
        @(negedge hash_clk); hit_nonce = 32'd9;
        @(negedge hash_clk); hit_valid = 1'b0;
        idle(5);
        checks++;
        if (pq.size() != 1 || golden_nonce !== 32'd7) begin
            errors++;
            $display("FAIL abort_first_pulse: got %0d pulses golden=%h expected 1 00000007", pq.size(), golden_nonce);
        end
        pulse_work(32'd50, 32'd60);
        checks++;
        if (core_valid !== 1'b1 || core_nonce !== 32'd50) begin
            errors++;
            $display("FAIL abort_restart: got valid=%b nonce=%h expected 1 00000032", core_valid, core_nonce);
        end
        idle(9);
        hit_valid = 1'b1;
        hit_nonce = 32'h77;
        @(negedge hash_clk);
        hit_valid = 1'b0;
        idle(600);
        checks++;
        if (pq.size() != 1) begin
            errors++;
            $display("FAIL abort_flush: got %0d pulses expected 1", pq.size());
        end
        checks++;
        if (golden_nonce !== 32'd7 || hit_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_hold: got golden=%h count=%0d expected 00000007 0", golden_nonce, hit_count);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_work(32'd0, 32'd99);
        idle(70);
        pq.delete();
        pt.delete();
        @(negedge hash_clk); hit_valid = 1'b1; hit_nonce = 32'd21;
        @(negedge hash_clk); hit_nonce = 32'd22;
        @(negedge hash_clk); hit_valid = 1'b0;
        idle(3);
        checks++;
        if (pq.size() != 1 || golden_nonce !== 32'd21) begin
            errors++;
            $display("FAIL rst_pre_pulse: got %0d pulses golden=%h expected 1 00000015", pq.size(), golden_nonce);
        end
        n = 0;
        while (core_valid === 1'b1 && n < 200) begin
            n++;
            @(negedge hash_clk);
        end
        idle(5);
        checks++;
        if (busy !== 1'b1 || core_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_drain: got busy=%b valid=%b expected 1 0", busy, core_valid);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({core_valid, busy, exhausted, new_golden_nonce, hit_overflow} !== 5'b0 || core_nonce !== 32'd0) begin
            errors++;
            $display("FAIL rst_async_flags: got %b nonce=%h expected 00000 0", {core_valid, busy, exhausted, new_golden_nonce, hit_overflow}, core_nonce);
        end
        checks++;
        if (golden_nonce !== 32'd0 || hit_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_async_golden: got golden=%h count=%0d expected 0 0", golden_nonce, hit_count);
        end
        @(negedge hash_clk);
        reset_n = 1'b1;
        pq.delete();
        pt.delete();
        idle(600);
        checks++;
        if (pq.size() != 0) begin errors++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", pq.size()); end
        checks++;
        if (busy !== 1'b0 || exhausted !== 1'b0 || core_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got busy=%b exh=%b valid=%b expected 0 0 0", busy, exhausted, core_valid);
        end
    endtask

    initial begin
        test_reset();
        test_range();
        test_wrap();
        test_gap();
        test_overflow();
        idle(260);
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
